addsub_serial_ctrl: RTL and testbench

Bit-serial add/subtract sequencer for the 4-bit adder/subtractor datapath. A single 1-bit full-adder cell is time-shared across all operand bits, LSB first, one bit per clock. The block owns the operand shift registers, the carry flip-flop and the control FSM. It presents a start/busy/done handshake to the host logic.

---
 rtl/addsub_serial_ctrl_if.sv | 46 ++++
 rtl/addsub_serial_ctrl.sv | 167 ++++++++++++++++
 tb/tb_addsub_serial_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_ctrl_if.sv
// ============================================================================
// Module      : addsub_serial_ctrl_if
// Description : Host-side bundle for the bit-serial add/subtract sequencer.
//               Carries the start request, operation select, operands and
//               the registered result/status signals.
//               master : host logic (drives request, observes result)
//               slave  : sequencer (observes request, drives result)
//               Optional o_zero is present when ADDSUB_ZERO_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addsub_serial_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic             o_zero;
`endif

    modport master (
        output i_start, i_sub, i_A, i_B,
`ifdef ADDSUB_ZERO_FLAG_EN
        input  o_zero,
`endif
        input  o_busy, o_done, o_sum, o_carry, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_A, i_B,
`ifdef ADDSUB_ZERO_FLAG_EN
        output o_zero,
`endif
        output o_busy, o_done, o_sum, o_carry, o_overflow
    );
endinterface

`default_nettype wire

// File: rtl/addsub_serial_ctrl.sv
// ============================================================================
// Module      : addsub_serial_ctrl
// Description : Bit-serial add/subtract sequencer. One full-adder cell is
//               time-shared over WIDTH bits, LSB first, one bit per clock.
//               Ports:
//                 i_clk   - system clock, rising edge
//                 i_reset - asynchronous active-high reset
//                 bus     - slave side of addsub_serial_ctrl_if
//                           (start/sub/A/B in, busy/done/sum/carry/overflow out)
//               Optional feature macro: ADDSUB_ZERO_FLAG_EN adds bus.o_zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    addsub_serial_ctrl_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state_q,    w_state_d;
    logic [WIDTH-1:0] r_a_q,        w_a_d;
    logic [WIDTH-1:0] r_b_q,        w_b_d;
    logic [WIDTH-1:0] r_res_q,      w_res_d;
    logic [CNT_W-1:0] r_cnt_q,      w_cnt_d;
    logic             r_c_q,        w_c_d;
    logic             r_busy_q,     w_busy_d;
    logic             r_done_q,     w_done_d;
    logic [WIDTH-1:0] r_sum_q,      w_sum_d;
    logic             r_carry_q,    w_carry_d;
    logic             r_ovf_q,      w_ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic             r_nz_q,       w_nz_d;
    logic             r_zero_q,     w_zero_d;
`endif

    logic w_accept;
    logic w_sum_bit;
    logic w_carry_out;

    // Start is only honoured when the adder cell is free.
    assign w_accept    = bus.i_start && ((r_state_q == S_IDLE) || (r_state_q == S_DONE));
    assign w_sum_bit   = r_a_q[0] ^ r_b_q[0] ^ r_c_q;
    assign w_carry_out = (r_a_q[0] & r_b_q[0]) | (r_a_q[0] & r_c_q) | (r_b_q[0] & r_c_q);

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_cnt_d   = r_cnt_q;
        w_c_d     = r_c_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        w_sum_d   = r_sum_q;
        w_carry_d = r_carry_q;
        w_ovf_d   = r_ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
        w_nz_d    = r_nz_q;
        w_zero_d  = r_zero_q;
`endif
        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_d = S_RUN;
                    w_a_d     = bus.i_A;
                    // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in.
                    w_b_d     = bus.i_B ^ {WIDTH{bus.i_sub}};
                    w_c_d     = bus.i_sub;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b1;
`ifdef ADDSUB_ZERO_FLAG_EN
                    w_nz_d    = 1'b0;
`endif
                end else begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                w_a_d   = {1'b0, r_a_q[WIDTH-1:1]};
                w_b_d   = {1'b0, r_b_q[WIDTH-1:1]};
                w_res_d = {w_sum_bit, r_res_q[WIDTH-1:1]};
                w_c_d   = w_carry_out;
                w_cnt_d = r_cnt_q + CNT_W'(1);
`ifdef ADDSUB_ZERO_FLAG_EN
                w_nz_d  = r_nz_q | w_sum_bit;
`endif
                if (r_cnt_q == C_LAST_BIT) begin
                    // MSB step: r_c_q is the carry into the MSB, needed for overflow.
                    w_state_d = S_DONE;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_sum_d   = {w_sum_bit, r_res_q[WIDTH-1:1]};
                    w_carry_d = w_carry_out;
                    w_ovf_d   = r_c_q ^ w_carry_out;
`ifdef ADDSUB_ZERO_FLAG_EN
                    w_zero_d  = ~(r_nz_q | w_sum_bit);
`endif
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_cnt_q   <= '0;
            r_c_q     <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_ovf_q   <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
            r_nz_q    <= 1'b0;
            r_zero_q  <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_cnt_q   <= w_cnt_d;
            r_c_q     <= w_c_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_sum_q   <= w_sum_d;
            r_carry_q <= w_carry_d;
            r_ovf_q   <= w_ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
            r_nz_q    <= w_nz_d;
            r_zero_q  <= w_zero_d;
`endif
        end
    end

    assign bus.o_busy     = r_busy_q;
    assign bus.o_done     = r_done_q;
    assign bus.o_sum      = r_sum_q;
    assign bus.o_carry    = r_carry_q;
    assign bus.o_overflow = r_ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
    assign bus.o_zero     = r_zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_addsub_serial_ctrl.sv
// ============================================================================
// Module      : tb_addsub_serial_ctrl
// Description : Scoreboard bench for addsub_serial_ctrl. Stimulus pushes the
//               hand-computed result of each operation; a monitor pops and
//               compares whenever o_done is seen. Handshake timing is checked
//               inline by the stimulus. o_zero is compared when
//               ADDSUB_ZERO_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_serial_ctrl;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [WIDTH-1:0] prev_sum;

    addsub_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    addsub_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: every o_done must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.o_done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done sum=%b got done=1 required no done", bus.o_sum);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_sum !== e.sum || bus.o_carry !== e.carry || bus.o_overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL result got sum=%b c=%b v=%b required sum=%b c=%b v=%b",
                             bus.o_sum, bus.o_carry, bus.o_overflow, e.sum, e.carry, e.ovf);
                end
`ifdef ADDSUB_ZERO_FLAG_EN
                checks++;
                if (bus.o_zero !== e.zero) begin
                    errors++;
                    $display("FAIL zero_flag got %b required %b", bus.o_zero, e.zero);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] s, input logic c, input logic v);
        exp_t e;
        e.sum   = s;
        e.carry = c;
        e.ovf   = v;
        e.zero  = (s == '0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        bus.i_A   = a;
        bus.i_B   = b;
        bus.i_sub = sub;
    endtask

    // Wait for o_done at negedges, bounded; returns with the bench on that negedge.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.o_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.o_done}, 32'd1);
    endtask

    // One isolated operation with handshake timing and result-hold checks.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        @(negedge clk);
        drive(a, b, sub);
        bus.i_start = 1'b1;
        push_exp(es, ec, ev);
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check("busy_run", {30'd0, bus.o_busy, bus.o_done}, 32'd2);
            check("sum_hold", {28'd0, bus.o_sum}, {28'd0, prev_sum});
            @(negedge clk);
        end
        check("done_slot", {30'd0, bus.o_busy, bus.o_done}, 32'd1);
        prev_sum = es;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        prev_sum    = '0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        drive('0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: all outputs stay zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", {24'd0, bus.o_busy, bus.o_done, bus.o_sum, bus.o_carry, bus.o_overflow}, 32'd0);
        end

        run_op(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op(4'b0111, 4'b0010, 1'b1, 4'b0101, 1'b1, 1'b0);
        run_op(4'b0010, 4'b0111, 1'b1, 4'b1011, 1'b0, 1'b0);

        // Start held high with operands changed mid-run, then back-to-back.
        @(negedge clk);
        drive(4'b1111, 4'b0001, 1'b0);
        bus.i_start = 1'b1;
        push_exp(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        drive(4'b0010, 4'b0011, 1'b0);
        push_exp(4'b0101, 1'b0, 1'b0);
        wait_done("done_first_b2b");
        @(negedge clk);
        bus.i_start = 1'b0;
        check("b2b_busy", {30'd0, bus.o_busy, bus.o_done}, 32'd2);
        check("b2b_sum_hold", {28'd0, bus.o_sum}, 32'h0);
        wait_done("done_second_b2b");
        prev_sum = 4'b0101;

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        drive(4'b0110, 4'b0011, 1'b0);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {24'd0, bus.o_busy, bus.o_done, bus.o_sum, bus.o_carry, bus.o_overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_reset", {31'd0, bus.o_done}, 32'd0);
        prev_sum = '0;
        run_op(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);

        // Zero-result and near-zero subtracts.
        run_op(4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);
        run_op(4'b0101, 4'b0100, 1'b1, 4'b0001, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
